// File: rtl/seqdet_pkg.sv
// seqdet_pkg: shared constants, config record and length legality check for seq_detector_prog
package seqdet_pkg;
  localparam int MAX_LEN_DEF = 8;
  localparam int CNT_W_DEF = 16;
  typedef struct packed {
    logic [MAX_LEN_DEF-1:0] pat;
    logic [$clog2(MAX_LEN_DEF+1)-1:0] len;
    logic ovl;
  } cfg_t;
  function automatic logic len_ok(input int len, input int lim);
    return len >= 1 && len <= lim;
  endfunction
endpackage

// File: rtl/seq_detector_prog_if.sv
// seq_detector_prog_if: config write, serial input and match/status bundle; master drives cfg/data/cnt_clr, slave returns match, match_cnt, cfg_err
interface seq_detector_prog_if
  import seqdet_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int LEN_W = $clog2(MAX_LEN+1)
) ();
  logic cfg_we;
  logic [MAX_LEN-1:0] cfg_pat;
  logic [LEN_W-1:0] cfg_len;
  logic cfg_ovl;
  logic cfg_err;
  logic in_valid;
  logic in_bit;
  logic match;
  logic [CNT_W-1:0] match_cnt;
  logic cnt_clr;
  modport master (
    output cfg_we, cfg_pat, cfg_len, cfg_ovl, in_valid, in_bit, cnt_clr,
    input cfg_err, match, match_cnt
  );
  modport slave (
    input cfg_we, cfg_pat, cfg_len, cfg_ovl, in_valid, in_bit, cnt_clr,
    output cfg_err, match, match_cnt
  );
endinterface

// File: rtl/seqdet_history.sv
// seqdet_history: bit history shift register with saturating fill count; shift accepts in_bit, clr empties both, outputs are the post-shift view
module seqdet_history #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W = $clog2(MAX_LEN+1)
) (
  input  logic clk,
  input  logic rst,
  input  logic shift,
  input  logic clr,
  input  logic in_bit,
  output logic [MAX_LEN-1:0] hist_nxt,
  output logic [LEN_W-1:0] fill_nxt
);
  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0] fill;
  always_comb begin
    hist_nxt = {hist[MAX_LEN-2:0], in_bit};
    fill_nxt = fill == LEN_W'(MAX_LEN) ? fill : fill + 1'b1;
  end
  always_ff @(posedge clk)
    if (rst || clr) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= hist_nxt;
      fill <= fill_nxt;
    end
endmodule

// File: rtl/seq_detector_prog.sv
// seq_detector_prog: runtime-programmable serial pattern detector; bus carries config writes, valid-qualified bits, match pulse, cfg_err pulse and saturating match_cnt
module seq_detector_prog
  import seqdet_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W = $clog2(MAX_LEN+1),
  parameter int CNT_W = CNT_W_DEF
) (
  input logic clk,
  input logic rst,
  seq_detector_prog_if.slave bus
);
  logic [MAX_LEN-1:0] pat, hist_nxt, mask;
  logic [LEN_W-1:0] len, fill_nxt;
  logic ovl, accept, cfg_ok, hit;
  always_comb begin
    accept = bus.in_valid & ~bus.cfg_we;
    cfg_ok = len_ok(int'(bus.cfg_len), MAX_LEN);
    // len == MAX_LEN wraps the shift to zero, so the decrement yields all ones
    mask = (MAX_LEN'(1) << len) - MAX_LEN'(1);
    hit = accept && ((hist_nxt ^ pat) & mask) == '0 && fill_nxt >= len;
  end
  // clearing hist on a non-overlap hit is harmless: the next hit needs len fresh bits anyway
  seqdet_history #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_hist (
    .clk(clk),
    .rst(rst),
    .shift(accept),
    .clr((bus.cfg_we & cfg_ok) | (hit & ~ovl)),
    .in_bit(bus.in_bit),
    .hist_nxt(hist_nxt),
    .fill_nxt(fill_nxt)
  );
  always_ff @(posedge clk)
    if (rst) begin
      bus.match <= 1'b0;
      bus.cfg_err <= 1'b0;
      bus.match_cnt <= '0;
      pat <= '0;
      len <= LEN_W'(MAX_LEN);
      ovl <= 1'b1;
    end else begin
      bus.match <= hit;
      bus.cfg_err <= bus.cfg_we & ~cfg_ok;
      bus.match_cnt <= bus.cnt_clr ? CNT_W'(hit) : bus.match_cnt + CNT_W'(hit && bus.match_cnt != '1);
      if (bus.cfg_we && cfg_ok) begin
        pat <= bus.cfg_pat;
        len <= bus.cfg_len;
        ovl <= bus.cfg_ovl;
      end
    end
endmodule

// File: tb/tb_seq_detector_prog.sv
// tb_seq_detector_prog: directed and random stimulus against a bit-queue reference model
module tb_seq_detector_prog;
  import seqdet_pkg::*;
  localparam int ML = 8;
  localparam int CW = 4;
  localparam int LW = $clog2(ML+1);
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  seq_detector_prog_if #(.MAX_LEN(ML), .CNT_W(CW)) bus ();
  seq_detector_prog #(.MAX_LEN(ML), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_cmp = 0;
  int n_bad = 0;
  bit q[$];
  cfg_t cfg;
  int cnt_m;
  logic em, ee;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".match"}, 32'(bus.match), 32'(em));
    chk({tag, ".cnt"}, 32'(bus.match_cnt), 32'(cnt_m));
    chk({tag, ".cfg_err"}, 32'(bus.cfg_err), 32'(ee));
  endtask
  // model: bits accepted since the last clear; a hit is the last len bits equal to the pattern
  task automatic cyc(input logic we, input logic [ML-1:0] p, input int l, input logic o,
                     input logic v, input logic b, input logic c);
    bit h;
    h = 0;
    ee = 0;
    if (we) begin
      if (len_ok(l, ML)) begin
        cfg.pat = p;
        cfg.len = LW'(l);
        cfg.ovl = o;
        q.delete();
      end else ee = 1;
    end else if (v) begin
      q.push_back(b);
      if (q.size() > ML) void'(q.pop_front());
      h = q.size() >= int'(cfg.len);
      if (h)
        for (int i = 0; i < int'(cfg.len); i++)
          if (q[q.size()-1-i] != cfg.pat[i]) h = 0;
      if (h && !cfg.ovl) q.delete();
    end
    em = h;
    if (c) cnt_m = 0;
    if (h && cnt_m < CMAX) cnt_m++;
    bus.cfg_we = we;
    bus.cfg_pat = p;
    bus.cfg_len = LW'(l);
    bus.cfg_ovl = o;
    bus.in_valid = v;
    bus.in_bit = b;
    bus.cnt_clr = c;
    @(posedge clk);
    #1;
    check_all("cyc");
  endtask
  task automatic feed(input string s);
    for (int i = 0; i < s.len(); i++) cyc(0, '0, 1, 0, 1, s[i] == "1", 0);
  endtask
  task automatic wr(input logic [ML-1:0] p, input int l, input logic o);
    cyc(1, p, l, o, 0, 0, 0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0, 1, 0, 0, 1, 0);
  endtask
  // a bit that would complete the pattern is presented during reset and must not produce match
  task automatic do_rst();
    rst = 1'b1;
    bus.cfg_we = 0;
    bus.cfg_pat = '0;
    bus.cfg_len = '0;
    bus.cfg_ovl = 0;
    bus.in_valid = 1;
    bus.in_bit = 1;
    bus.cnt_clr = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 0;
    q.delete();
    cfg.pat = '0;
    cfg.len = LW'(ML);
    cfg.ovl = 1;
    cnt_m = 0;
    em = 0;
    ee = 0;
    check_all("reset");
  endtask
  initial begin
    do_rst();
    feed("00000000");
    do_rst();
    wr(8'b11011, 5, 0);
    feed("1101111011");
    chk("tp1_cnt2", 32'(bus.match_cnt), 32'd2);
    wr(8'b101, 3, 1);
    feed("10101");
    wr(8'b101, 3, 0);
    feed("10101");
    wr(8'b11, 2, 1);
    feed("1");
    idle(3);
    feed("1");
    wr(8'b101, 3, 1);
    feed("10");
    wr(8'hff, 0, 0);
    chk("illegal0_err", 32'(bus.cfg_err), 32'd1);
    wr(8'hff, ML + 1, 0);
    chk("illegal9_err", 32'(bus.cfg_err), 32'd1);
    feed("1");
    chk("inprog_match", 32'(bus.match), 32'd1);
    feed("01");
    feed("10");
    cyc(1, 8'b101, 3, 1, 1, 1, 0);
    chk("collide_nomatch", 32'(bus.match), 32'd0);
    feed("1");
    feed("10");
    cyc(0, '0, 1, 0, 1, 1, 1);
    chk("clr_hit_cnt1", 32'(bus.match_cnt), 32'd1);
    wr(8'b1, 1, 1);
    for (int i = 0; i < 20; i++) feed("1");
    chk("sat_cnt", 32'(bus.match_cnt), 32'(CMAX));
    wr(8'b101, 3, 1);
    feed("10");
    do_rst();
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      cyc(r < 6, ML'($urandom), $urandom_range(0, 10), 1'($urandom),
          $urandom_range(0, 99) < 75, 1'($urandom), $urandom_range(0, 39) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/seq_detector_prog.md
# seq_detector_prog

Runtime-programmable serial pattern detector.
- Pattern length, pattern value and overlap mode are loaded through a config port, not fixed at elaboration.
- Counts matches in a saturating counter.
- Sits on a serial bit stream behind a valid qualifier; feeds match pulses and counts to control/status logic.
- Supersedes fixed-pattern, fixed-mode detectors: one instance covers overlapping and non-overlapping detection of any length 1..MAX_LEN.

## Interface
Parameters:
- MAX_LEN, 8: maximum pattern length in bits (≥2).
- LEN_W, $clog2(MAX_LEN+1): width of length fields.
- CNT_W, 16: width of the match counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- cfg_we  in  1  config write strobe.
- cfg_pat  in  MAX_LEN  pattern; bits [len-1:0] used; bit len-1 is the first bit received.
- cfg_len  in  LEN_W  pattern length, legal 1..MAX_LEN.
- cfg_ovl  in  1  1 = overlapping, 0 = non-overlapping.
- cfg_err  out  1  one-cycle pulse when a write is rejected.
- in_valid  in  1  in_bit is sampled this cycle.
- in_bit  in  1  serial data bit.
- match  out  1  one-cycle registered pulse on detection.
- match_cnt  out  CNT_W  saturating count of matches.
- cnt_clr  in  1  clears match_cnt.

## Operation
- State:
  - hist[MAX_LEN-1:0]: newest bit in LSB.
  - fill: 0..MAX_LEN, saturating count of bits accepted since the last clear.
  - Config registers pat, len, ovl.
- Accepted bit (in_valid=1, cfg_we=0):
  - hist ← {hist[MAX_LEN-2:0], in_bit}.
  - fill ← min(fill+1, MAX_LEN).
- Hit: new hist[len-1:0] == pat[len-1:0] and new fill ≥ len.
- On hit:
  - match=1 next cycle.
  - match_cnt increments, saturating at 2^CNT_W−1.
  - If ovl=0, fill ← 0, so the next hit needs len fresh bits.
  - If ovl=1, fill is unchanged.
- No hit: match=0. Cycles with in_valid=0 leave all state unchanged and produce match=0.
- Config write with cfg_len in 1..MAX_LEN:
  - Load pat, len, ovl.
  - Clear hist and fill.
  - match_cnt is kept.
- Config write with cfg_len = 0 or > MAX_LEN:
  - Config unchanged.
  - cfg_err=1 next cycle.
  - hist and fill are unchanged.
- cnt_clr: match_cnt ← 0. If a hit occurs in the same cycle, the counter result is 1 (clear then increment).
- Reset values:
  - match=0, cfg_err=0, match_cnt=0.
  - hist=0, fill=0.
  - pat=0, len=MAX_LEN, ovl=1.

## Timing
- Latency: match asserts in cycle N+1 for the accepted bit of cycle N that completes the pattern (Moore-style registered output). It is never combinational from in_bit.
- Back-to-back hits, ovl=1: match can be high on consecutive cycles, e.g. len=1, or pattern 11 on stream 111.
- Back-to-back hits, ovl=0: the minimum spacing between match pulses is len accepted bits.
- cfg_we and in_valid in the same cycle: config wins. The bit is dropped and match=0 next cycle.
- cfg_err asserts one cycle after the rejected write.
- New config takes effect on the first bit accepted after the write cycle.
- rst has priority over everything. Reset asserted mid-pattern discards partial history; a hit in the reset cycle does not produce match.
- fill saturation: after MAX_LEN accepted bits, fill stays at MAX_LEN with no wrap.

## Structure
- Package seqdet_pkg:
  - Default constants MAX_LEN_DEF=8 and CNT_W_DEF=16.
  - Function len_ok(len, max) used by RTL and bench.
  - Typedef for the config record {pat, len, ovl}.
- Sub-module seqdet_history:
  - Contents: shift register hist plus saturating fill counter.
  - Inputs: shift enable, clear (cfg load / non-overlap hit), in_bit.
  - Outputs: hist, fill.
- Top level holds the config registers, masked comparator, match/cfg_err registers and match_cnt.

## Test plan
- Reset defaults: after rst, match=0, match_cnt=0. Write pat=5'b11011, len=5, ovl=0; stream 1101111011 → match pulses one cycle after bits 5 and 10; match_cnt=2.
- Overlap: pat=3'b101, len=3, ovl=1; stream 10101 → match after bits 3 and 5; with ovl=0 the same stream gives a match after bit 3 only.
- Valid gating: pat=2'b11, len=2; bits 1, (in_valid=0 gap of 3 cycles), 1 → single match one cycle after the second valid bit; no match during the gap.
- Illegal config: cfg_len=0, then cfg_len=MAX_LEN+1 → cfg_err pulses each time. The old pattern is still detected afterwards, and a detection already in progress completes.
- Collision: cfg_we and in_valid together on the completing bit → no match, hist cleared. cnt_clr together with a hit → match_cnt=1.
- Saturation and reset: CNT_W=4, len=1, pat=1, ovl=1, stream of 20 ones → match_cnt holds at 15. Assert rst mid-pattern → all outputs return to reset values next cycle.
